mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit that drives the 32-bit ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Each cycle it issues the 4-bit ALU op code, the ALU operand selects and all datapath enables.
- It consumes the ALU zero flag to resolve beq.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); not intended to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]; stable from the cycle after FETCH
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag (combinational from the ALU in the same cycle)
- alu_op  output  4  AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100
- alu_src_a  output  1  0=PC, 1=A register
- alu_src_b  output  2  00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2
- pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_en  output  1  PC load = pc_write | (branch & zero)
- iord  output  1  memory address select, 0=PC, 1=ALUOut
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction register load
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=MDR
- reg_write  output  1  register file write enable
- instr_done  output  1  1-cycle pulse in the final cycle of each instruction
- illegal  output  1  1-cycle pulse on an unsupported opcode or funct
- state  output  4  current state, for debug

Behaviour:
- Single clock domain. reset is synchronous and active-high. On a clk edge with reset=1, state<=FETCH.
- While reset=1, all enables are forced to 0: pc_en, ir_write, mem_write, reg_write, instr_done, illegal. The mux selects show FETCH values.
- Outputs are a Moore decode of state. The exceptions are pc_en in BEQ (depends on zero) and alu_op in RTYPE_EX (depends on funct).
- Default for any output not listed for a state: 0. Default alu_op is ADD.

State encodings, outputs and transitions:
- FETCH(0): iord=0, src_a=0, src_b=01, ADD, pc_src=00, ir_write=1, pc_en=1. -> DECODE.
- DECODE(1): src_a=0, src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - lw 100011 or sw 101011 -> MEMADR
  - R 000000 -> RTYPE_EX
  - beq 000100 -> BEQ
  - addi 001000 -> ADDI_EX
  - j 000010 -> JUMP
  - any other opcode: illegal=1, instr_done=1, -> FETCH
- MEMADR(2): src_a=1, src_b=10, ADD. -> MEMRD if lw, MEMWR if sw.
- MEMRD(3): iord=1. -> MEMWB.
- MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. -> FETCH.
- MEMWR(5): iord=1, mem_write=1, instr_done=1. -> FETCH.
- RTYPE_EX(6): src_a=1, src_b=00. alu_op from funct:
  - 100000 -> ADD; 100010 -> SUB; 100100 -> AND; 100101 -> OR; 100111 -> NOR; 101010 -> SLT.
  - Valid funct -> RTYPE_WB.
  - Other funct: alu_op=ADD, illegal=1, instr_done=1, -> FETCH; no register write occurs.
- RTYPE_WB(7): reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
- BEQ(8): src_a=1, src_b=00, SUB, pc_src=01, pc_en=zero, instr_done=1. -> FETCH.
- ADDI_EX(9): src_a=1, src_b=10, ADD. -> ADDI_WB.
- ADDI_WB(10): reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
- JUMP(11): pc_src=10, pc_en=1, instr_done=1. -> FETCH.
- Encodings 12-15: -> FETCH, illegal=1, all enables 0.

Latency (cycles per instruction, counted from FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.

Reset mid-instruction: the next state is FETCH. No write enable is asserted in the reset cycle, including MEMWR and RTYPE_WB.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the ALU op code constants (shared with the ALU)
  - opcode and funct constants
  - the state encoding enum
- Sub-module alu_decoder: funct -> {alu_op, funct_valid}, purely combinational, used in RTYPE_EX.

Test Plan:
- Reset: hold reset 2 cycles while state=MEMWR -> mem_write=0 during reset; state=0 after release; first cycle shows ir_write=1, pc_en=1, alu_op=0010, src_b=01.
- lw (opcode 100011): state sequence 0,1,2,3,4 -> MEMWB shows reg_write=1, mem_to_reg=1; instr_done pulses only in cycle 5.
- R-type with funct 101010 -> RTYPE_EX alu_op=0111. Sweep the other five functs -> 0010, 0110, 0000, 0001, 1100. funct 000000 -> illegal=1, no RTYPE_WB, reg_write stays 0.
- beq with zero=1 in cycle 3 -> pc_en=1, pc_src=01, alu_op=0110. Repeat with zero=0 -> pc_en=0; next state FETCH in both cases.
- j: 3 cycles, pc_en=1 with pc_src=10. Unknown opcode 111111 -> illegal and instr_done in DECODE, back to FETCH in 2 cycles.
- sw followed by addi back-to-back -> mem_write exactly 1 cycle (state 5); addi reg_write in state 10 with reg_dst=0; instr_done count = 2.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit and its ALU:
// ALU op codes, instruction opcode/funct fields and the FSM state encoding.
package mips_ctrl_pkg;

    localparam int ALU_OP_W = 4;

    // ALU operation codes (shared with the 32-bit ALU)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Instruction opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, IR[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // FSM state encoding; 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle: instruction fields and ALU flag in, control
// selects and enables out. master = control unit, slave = datapath.
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_src;
    logic                pc_en;
    logic                iord;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                instr_done;
    logic                illegal;
    logic [3:0]          state;

    modport master (
        input  opcode, funct, zero,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal, state
    );

endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU op decoder. Unsupported functs fall back to ADD and
// drop funct_valid so the FSM can flag them without writing a register.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]          funct_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                funct_valid_o
);

    // Map funct to ALU operation
    always_comb begin
        alu_op_o      = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_NOR:  alu_op_o = ALU_NOR;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: begin
                alu_op_o      = ALU_ADD;
                funct_valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Outputs are a Moore decode of the state,
// except pc_en in BEQ (follows zero) and alu_op in RTYPE_EX (follows funct).
// While reset is high every enable is held low and the selects show FETCH.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [3:0] ST_FETCH    = S_FETCH;
    localparam logic [3:0] ST_DECODE   = S_DECODE;
    localparam logic [3:0] ST_MEMADR   = S_MEMADR;
    localparam logic [3:0] ST_MEMRD    = S_MEMRD;
    localparam logic [3:0] ST_MEMWB    = S_MEMWB;
    localparam logic [3:0] ST_MEMWR    = S_MEMWR;
    localparam logic [3:0] ST_RTYPE_EX = S_RTYPE_EX;
    localparam logic [3:0] ST_RTYPE_WB = S_RTYPE_WB;
    localparam logic [3:0] ST_BEQ      = S_BEQ;
    localparam logic [3:0] ST_ADDI_EX  = S_ADDI_EX;
    localparam logic [3:0] ST_ADDI_WB  = S_ADDI_WB;
    localparam logic [3:0] ST_JUMP     = S_JUMP;

    logic [3:0]          state_q, state_d;
    logic [ALU_OP_W-1:0] rtype_op_s;
    logic                funct_valid_s;

    logic [ALU_OP_W-1:0] alu_op_s;
    logic                src_a_s, pc_en_s, iord_s, mem_write_s, ir_write_s;
    logic [1:0]          src_b_s, pc_src_s;
    logic                reg_dst_s, mem_to_reg_s, reg_write_s, done_s, illegal_s;

    alu_decoder u_alu_decoder (
        .funct_i       (bus.funct),
        .alu_op_o      (rtype_op_s),
        .funct_valid_o (funct_valid_s)
    );

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state control decode
    always_comb begin
        state_d      = ST_FETCH;
        alu_op_s     = ALU_ADD;
        src_a_s      = 1'b0;
        src_b_s      = 2'b00;
        pc_src_s     = 2'b00;
        pc_en_s      = 1'b0;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        done_s       = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                src_b_s    = 2'b01;
                ir_write_s = 1'b1;
                pc_en_s    = 1'b1;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target PC + (imm<<2) is computed speculatively here
                src_b_s = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_RTYPE_EX;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        illegal_s = 1'b1;
                        done_s    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                src_a_s = 1'b1;
                src_b_s = 2'b10;
                if (bus.opcode == OP_LW) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                iord_s  = 1'b1;
                state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
                done_s       = 1'b1;
            end
            ST_MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                done_s      = 1'b1;
            end
            ST_RTYPE_EX: begin
                src_a_s  = 1'b1;
                alu_op_s = rtype_op_s;
                if (funct_valid_s) begin
                    state_d = ST_RTYPE_WB;
                end else begin
                    illegal_s = 1'b1;
                    done_s    = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_RTYPE_WB: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            ST_BEQ: begin
                src_a_s  = 1'b1;
                alu_op_s = ALU_SUB;
                pc_src_s = 2'b01;
                pc_en_s  = bus.zero;
                done_s   = 1'b1;
            end
            ST_ADDI_EX: begin
                src_a_s = 1'b1;
                src_b_s = 2'b10;
                state_d = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            ST_JUMP: begin
                pc_src_s = 2'b10;
                pc_en_s  = 1'b1;
                done_s   = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
                state_d   = ST_FETCH;
            end
        endcase
    end

    // Output stage: reset masks enables and shows FETCH selects
    always_comb begin
        bus.state = state_q;
        if (reset) begin
            bus.alu_op     = ALU_ADD;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = 2'b01;
            bus.pc_src     = 2'b00;
            bus.pc_en      = 1'b0;
            bus.iord       = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
            bus.reg_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end else begin
            bus.alu_op     = alu_op_s;
            bus.alu_src_a  = src_a_s;
            bus.alu_src_b  = src_b_s;
            bus.pc_src     = pc_src_s;
            bus.pc_en      = pc_en_s;
            bus.iord       = iord_s;
            bus.mem_write  = mem_write_s;
            bus.ir_write   = ir_write_s;
            bus.reg_dst    = reg_dst_s;
            bus.mem_to_reg = mem_to_reg_s;
            bus.reg_write  = reg_write_s;
            bus.instr_done = done_s;
            bus.illegal    = illegal_s;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each stimulus cycle pushes the
// hand-written expected control word; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] op;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pe;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rd;
        logic       m2r;
        logic       rw;
        logic       dn;
        logic       il;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    mips_multicycle_ctrl_if bus_if ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    fails  = 0;

    function automatic exp_t mk(input logic [3:0] st, input logic [3:0] op,
                                input logic sa, input logic [1:0] sb,
                                input logic [1:0] ps, input logic pe,
                                input logic iord, input logic mw, input logic irw,
                                input logic rd, input logic m2r, input logic rw,
                                input logic dn, input logic il);
        exp_t e;
        e = '{st, op, sa, sb, ps, pe, iord, mw, irw, rd, m2r, rw, dn, il};
        return e;
    endfunction

    // Commonly used expected words
    function automatic exp_t e_fetch();
        return mk(4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_decode();
        return mk(4'd1, 4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_reset(input logic [3:0] st);
        return mk(st, 4'b0010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Drive one cycle and queue its expected outputs
    task automatic step(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                        input logic rst, input exp_t e, input string nm);
        bus_if.opcode = opc;
        bus_if.funct  = fn;
        bus_if.zero   = z;
        reset         = rst;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the queue head mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {bus_if.state, bus_if.alu_op, bus_if.alu_src_a, bus_if.alu_src_b,
                  bus_if.pc_src, bus_if.pc_en, bus_if.iord, bus_if.mem_write,
                  bus_if.ir_write, bus_if.reg_dst, bus_if.mem_to_reg,
                  bus_if.reg_write, bus_if.instr_done, bus_if.illegal};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d op=%b sa=%b sb=%b ps=%b pe=%b iord=%b mw=%b irw=%b rd=%b m2r=%b rw=%b dn=%b il=%b ; want st=%0d op=%b sa=%b sb=%b ps=%b pe=%b iord=%b mw=%b irw=%b rd=%b m2r=%b rw=%b dn=%b il=%b",
                         nm, a.st, a.op, a.sa, a.sb, a.ps, a.pe, a.iord, a.mw, a.irw, a.rd, a.m2r, a.rw, a.dn, a.il,
                         e.st, e.op, e.sa, e.sb, e.ps, e.pe, e.iord, e.mw, e.irw, e.rd, e.m2r, e.rw, e.dn, e.il);
            end
        end
    end

    logic [5:0] fn_tab [6];
    logic [3:0] op_tab [6];

    initial begin
        fn_tab = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111};
        op_tab = '{4'b0111,   4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b1100};

        reset         = 1'b1;
        bus_if.opcode = 6'b000000;
        bus_if.funct  = 6'b000000;
        bus_if.zero   = 1'b0;
        @(posedge clk);
        #1;

        // sw interrupted by reset while in MEMWR
        step(OP_SW, 6'd0, 1'b0, 1'b0, e_fetch(),  "sw fetch");
        step(OP_SW, 6'd0, 1'b0, 1'b0, e_decode(), "sw decode");
        step(OP_SW, 6'd0, 1'b0, 1'b0,
             mk(4'd2, 4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sw memadr");
        step(OP_SW, 6'd0, 1'b0, 1'b1, e_reset(4'd5), "reset in memwr");
        step(OP_SW, 6'd0, 1'b0, 1'b1, e_reset(4'd0), "reset held");

        // lw: 5 cycles
        step(OP_LW, 6'd0, 1'b0, 1'b0, e_fetch(),  "lw fetch after reset");
        step(OP_LW, 6'd0, 1'b0, 1'b0, e_decode(), "lw decode");
        step(OP_LW, 6'd0, 1'b0, 1'b0,
             mk(4'd2, 4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lw memadr");
        step(OP_LW, 6'd0, 1'b0, 1'b0,
             mk(4'd3, 4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lw memrd");
        step(OP_LW, 6'd0, 1'b0, 1'b0,
             mk(4'd4, 4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), "lw memwb");

        // R-type funct sweep
        for (int i = 0; i < 6; i++) begin
            step(OP_RTYPE, fn_tab[i], 1'b0, 1'b0, e_fetch(),  "r fetch");
            step(OP_RTYPE, fn_tab[i], 1'b0, 1'b0, e_decode(), "r decode");
            step(OP_RTYPE, fn_tab[i], 1'b0, 1'b0,
                 mk(4'd6, op_tab[i], 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "r ex");
            step(OP_RTYPE, fn_tab[i], 1'b0, 1'b0,
                 mk(4'd7, 4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), "r wb");
        end

        // Unsupported funct: illegal in RTYPE_EX, no writeback
        step(OP_RTYPE, 6'b000000, 1'b0, 1'b0, e_fetch(),  "badfn fetch");
        step(OP_RTYPE, 6'b000000, 1'b0, 1'b0, e_decode(), "badfn decode");
        step(OP_RTYPE, 6'b000000, 1'b0, 1'b0,
             mk(4'd6, 4'b0010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), "badfn ex");

        // beq taken and not taken
        step(OP_BEQ, 6'd0, 1'b0, 1'b0, e_fetch(),  "beq1 fetch");
        step(OP_BEQ, 6'd0, 1'b0, 1'b0, e_decode(), "beq1 decode");
        step(OP_BEQ, 6'd0, 1'b1, 1'b0,
             mk(4'd8, 4'b0110, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "beq taken");
        step(OP_BEQ, 6'd0, 1'b0, 1'b0, e_fetch(),  "beq0 fetch");
        step(OP_BEQ, 6'd0, 1'b1, 1'b0, e_decode(), "beq0 decode");
        step(OP_BEQ, 6'd0, 1'b0, 1'b0,
             mk(4'd8, 4'b0110, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "beq not taken");

        // j
        step(OP_J, 6'd0, 1'b0, 1'b0, e_fetch(),  "j fetch");
        step(OP_J, 6'd0, 1'b0, 1'b0, e_decode(), "j decode");
        step(OP_J, 6'd0, 1'b0, 1'b0,
             mk(4'd11, 4'b0010, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "j jump");

        // Unknown opcode: illegal in DECODE
        step(6'b111111, 6'd0, 1'b0, 1'b0, e_fetch(), "badop fetch");
        step(6'b111111, 6'd0, 1'b0, 1'b0,
             mk(4'd1, 4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), "badop decode");

        // sw then addi back-to-back
        step(OP_SW, 6'd0, 1'b0, 1'b0, e_fetch(),  "sw2 fetch");
        step(OP_SW, 6'd0, 1'b0, 1'b0, e_decode(), "sw2 decode");
        step(OP_SW, 6'd0, 1'b0, 1'b0,
             mk(4'd2, 4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sw2 memadr");
        step(OP_SW, 6'd0, 1'b0, 1'b0,
             mk(4'd5, 4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "sw2 memwr");
        step(OP_ADDI, 6'd0, 1'b0, 1'b0, e_fetch(),  "addi fetch");
        step(OP_ADDI, 6'd0, 1'b0, 1'b0, e_decode(), "addi decode");
        step(OP_ADDI, 6'd0, 1'b0, 1'b0,
             mk(4'd9, 4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "addi ex");
        step(OP_ADDI, 6'd0, 1'b0, 1'b0,
             mk(4'd10, 4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "addi wb");
        step(OP_ADDI, 6'd0, 1'b0, 1'b0, e_fetch(), "final fetch");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
